// File: rtl/ppm_pkg.sv
// Shared constants, control struct and elaboration-time helpers for the ppm_mac
// carry-save multiply-accumulate block.
package ppm_pkg;

  localparam int MULT_WALLACE = 0;
  localparam int MULT_DADDA   = 1;

  typedef struct packed {
    logic vld;
    logic acc_en;
    logic acc_clr;
  } ctrl_t;

  function automatic int acc_w_def(input int n, input int m);
    return n + m + 8;
  endfunction

  // Baugh-Wooley constant for an nx-by-my signed array whose negative-weight
  // partial-product bits are stored inverted: minus the sum of those weights.
  function automatic logic [127:0] bw_corr(input int nx, input int my);
    logic [127:0] s;
    s = '0;
    for (int j = 0; j < my - 1; j++) s = s + (128'd1 << (nx - 1 + j));
    for (int i = 0; i < nx - 1; i++) s = s + (128'd1 << (i + my - 1));
    return -s;
  endfunction

  // Number of 3:2 compressors used on a level holding c rows; the tree stops at 3.
  function automatic int red_cnt(input int c, input int mult);
    int d;
    int n;
    if (c <= 3) return 0;
    if (mult == MULT_DADDA) begin
      d = 3;
      while ((d * 3) / 2 < c) d = (d * 3) / 2;
      n = c - d;
      if (n > c / 3) n = c / 3;
    end else begin
      n = c / 3;
    end
    return n;
  endfunction

  function automatic int rows_at(input int r, input int lvl, input int mult);
    int c;
    c = r;
    for (int l = 0; l < lvl; l++) c = c - red_cnt(c, mult);
    return c;
  endfunction

  function automatic int num_lvls(input int r, input int mult);
    int c;
    int l;
    c = r;
    l = 0;
    while (c > 3) begin
      c = c - red_cnt(c, mult);
      l++;
    end
    return l;
  endfunction

endpackage

// File: rtl/ppm_csa42.sv
// Vector 3:2 compressor and the 4:2 carry-save adder built from two of them.
// Carries shift left within W bits, so every sum is modulo 2^W.
module ppm_compressor32 #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_c,
  output logic [W-1:0] o_s,
  output logic [W-1:0] o_c
);
  logic [W-1:0] w_maj;

  assign o_s   = i_a ^ i_b ^ i_c;
  assign w_maj = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
  assign o_c   = w_maj << 1;
endmodule

module ppm_csa42 #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_c,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_s,
  output logic [W-1:0] o_c
);
  logic [W-1:0] w_s1, w_c1;

  ppm_compressor32 #(.W(W)) u_lo (
    .i_a(i_a), .i_b(i_b), .i_c(i_c), .o_s(w_s1), .o_c(w_c1)
  );
  ppm_compressor32 #(.W(W)) u_hi (
    .i_a(w_s1), .i_b(w_c1), .i_c(i_d), .o_s(o_s), .o_c(o_c)
  );
endmodule

// File: rtl/ppm_tree.sv
// Baugh-Wooley partial products reduced to three rows by a Wallace or Dadda
// schedule of 3:2 compressors; the sign constant is added downstream.
module ppm_tree
  import ppm_pkg::*;
#(
  parameter int NX   = 18,
  parameter int MY   = 18,
  parameter int W    = 42,
  parameter int MULT = MULT_WALLACE
) (
  input  logic [NX-1:0] i_x,
  input  logic [MY-1:0] i_y,
  output logic [W-1:0]  o_r0,
  output logic [W-1:0]  o_r1,
  output logic [W-1:0]  o_r2
);
  localparam int NL = num_lvls(MY, MULT);

  logic [W-1:0] w_lv [NL+1][MY];

  // Only the bits whose weight is negative (exactly one operand MSB) are inverted.
  for (genvar j = 0; j < MY; j++) begin : g_pp
    localparam logic [NX-1:0] INV = (j == MY - 1) ? {1'b0, {(NX-1){1'b1}}}
                                                  : {1'b1, {(NX-1){1'b0}}};
    assign w_lv[0][j] = W'((i_x & {NX{i_y[j]}}) ^ INV) << j;
  end

  for (genvar l = 1; l <= NL; l++) begin : g_lvl
    localparam int PC = rows_at(MY, l - 1, MULT);
    localparam int NR = red_cnt(PC, MULT);
    localparam int CC = PC - NR;

    for (genvar g = 0; g < NR; g++) begin : g_csa
      ppm_compressor32 #(.W(W)) u_c (
        .i_a(w_lv[l-1][3*g]),
        .i_b(w_lv[l-1][3*g+1]),
        .i_c(w_lv[l-1][3*g+2]),
        .o_s(w_lv[l][2*g]),
        .o_c(w_lv[l][2*g+1])
      );
    end
    for (genvar k = 3 * NR; k < PC; k++) begin : g_pass
      assign w_lv[l][k-NR] = w_lv[l-1][k];
    end
    for (genvar k = CC; k < MY; k++) begin : g_tie
      assign w_lv[l][k] = '0;
    end
  end

  assign o_r0 = w_lv[NL][0];
  assign o_r1 = w_lv[NL][1];
  assign o_r2 = w_lv[NL][2];
endmodule

// File: rtl/ppm_mac.sv
// Pipelined signed/unsigned multiply-accumulate with carry-save product, output
// and accumulator; a single stall enable freezes every stage under back-pressure.
module ppm_mac
  import ppm_pkg::*;
#(
  parameter int N     = 17,
  parameter int M     = 17,
  parameter int MULT  = MULT_WALLACE,
  parameter int PIPE  = 2,
  parameter int ACC_W = acc_w_def(N, M)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [M-1:0]     b,
  input  logic             tc,
  input  logic             acc_en,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out1,
  output logic [ACC_W-1:0] out2
);
  localparam int           W         = ACC_W;
  localparam logic [127:0] CORR_FULL = bw_corr(N + 1, M + 1);
  localparam logic [W-1:0] CORR      = CORR_FULL[W-1:0];

  logic         w_en, w_add;
  logic [N:0]   w_x;
  logic [M:0]   w_y;
  ctrl_t        w_c0, w_c1, w_c2;
  logic [W-1:0] w_t0, w_t1, w_t2, w_b0, w_b1, w_b2;
  logic [W-1:0] w_ps, w_pc, w_qs, w_qc, w_rs, w_rc, w_add_s, w_add_c;
  logic         r_out_valid;
  logic [W-1:0] r_out1, r_out2, r_acc_s, r_acc_c;

  assign w_en     = !r_out_valid || out_ready;
  assign in_ready = w_en && !rst;

  // One extra operand bit makes unsigned inputs fit the signed array.
  assign w_x  = {tc & a[N-1], a};
  assign w_y  = {tc & b[M-1], b};
  assign w_c0 = '{vld: in_valid && in_ready, acc_en: acc_en, acc_clr: acc_clr};

  ppm_tree #(.NX(N + 1), .MY(M + 1), .W(W), .MULT(MULT)) u_tree (
    .i_x(w_x), .i_y(w_y), .o_r0(w_t0), .o_r1(w_t1), .o_r2(w_t2)
  );

  if (PIPE >= 3) begin : g_s1
    logic [W-1:0] r_t0, r_t1, r_t2;
    ctrl_t        r_c;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_t0 <= '0;
        r_t1 <= '0;
        r_t2 <= '0;
        r_c  <= '0;
      end else if (w_en) begin
        r_t0 <= w_t0;
        r_t1 <= w_t1;
        r_t2 <= w_t2;
        r_c  <= w_c0;
      end
    end
    assign w_b0 = r_t0;
    assign w_b1 = r_t1;
    assign w_b2 = r_t2;
    assign w_c1 = r_c;
  end else begin : g_s1_byp
    assign w_b0 = w_t0;
    assign w_b1 = w_t1;
    assign w_b2 = w_t2;
    assign w_c1 = w_c0;
  end

  ppm_csa42 #(.W(W)) u_corr (
    .i_a(w_b0), .i_b(w_b1), .i_c(w_b2), .i_d(CORR), .o_s(w_ps), .o_c(w_pc)
  );

  if (PIPE >= 2) begin : g_s2
    logic [W-1:0] r_ps, r_pc;
    ctrl_t        r_c;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_ps <= '0;
        r_pc <= '0;
        r_c  <= '0;
      end else if (w_en) begin
        r_ps <= w_ps;
        r_pc <= w_pc;
        r_c  <= w_c1;
      end
    end
    assign w_qs = r_ps;
    assign w_qc = r_pc;
    assign w_c2 = r_c;
  end else begin : g_s2_byp
    assign w_qs = w_ps;
    assign w_qc = w_pc;
    assign w_c2 = w_c1;
  end

  // ACC is added in the output stage so a dependent successor sees it next cycle.
  assign w_add   = w_c2.acc_en && !w_c2.acc_clr;
  assign w_add_s = w_add ? r_acc_s : '0;
  assign w_add_c = w_add ? r_acc_c : '0;

  ppm_csa42 #(.W(W)) u_acc (
    .i_a(w_qs), .i_b(w_qc), .i_c(w_add_s), .i_d(w_add_c), .o_s(w_rs), .o_c(w_rc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out1      <= '0;
      r_out2      <= '0;
      r_acc_s     <= '0;
      r_acc_c     <= '0;
    end else if (w_en) begin
      r_out_valid <= w_c2.vld;
      if (w_c2.vld) begin
        r_out1 <= w_rs;
        r_out2 <= w_rc;
        if (w_c2.acc_en) begin
          r_acc_s <= w_rs;
          r_acc_c <= w_rc;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out1      = r_out1;
  assign out2      = r_out2;
endmodule

// File: tb/tb_ppm_mac.sv
// Directed bench for ppm_mac: default 17x17/42-bit instance plus a bank of
// 34-bit instances covering both trees and every pipeline depth.
module tb_ppm_mac;
  import ppm_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, tc, acc_en, acc_clr, out_valid, out_ready;
  logic [16:0] a, b;
  logic [41:0] out1, out2, sum;
  int          checks = 0;
  int          errors = 0;

  ppm_mac #(.N(17), .M(17), .MULT(MULT_WALLACE), .PIPE(2), .ACC_W(42)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .tc(tc), .acc_en(acc_en), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out1(out1), .out2(out2)
  );
  assign sum = out1 + out2;

  logic             w_valid, w_clr;
  logic [5:0]       w_ir, w_ov;
  logic [5:0][33:0] w_o1, w_o2;

  for (genvar i = 0; i < 6; i++) begin : g_w
    ppm_mac #(.N(17), .M(17), .MULT(i / 3), .PIPE(i % 3 + 1), .ACC_W(34)) u (
      .clk(clk), .rst(rst), .in_valid(w_valid), .in_ready(w_ir[i]),
      .a(17'h1FFFF), .b(17'h1FFFF), .tc(1'b0), .acc_en(1'b1), .acc_clr(w_clr),
      .out_valid(w_ov[i]), .out_ready(1'b1), .out1(w_o1[i]), .out2(w_o2[i])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [16:0] ia, input logic [16:0] ib,
                       input logic itc, input logic ien, input logic iclr);
    in_valid = v;
    a        = ia;
    b        = ib;
    tc       = itc;
    acc_en   = ien;
    acc_clr  = iclr;
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b1; w_valid = 1'b0; w_clr = 1'b0;
    drive(1'b0, 17'h0, 17'h0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out1", out1, 0);
    chk("rst_out2", out2, 0);
    rst = 1'b0;
    #1;
    chk("release_in_ready", in_ready, 1);

    // unsigned max and exact latency
    drive(1'b1, 17'h1FFFF, 17'h1FFFF, 1'b0, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("lat_not_early", out_valid, 0);
    tick();
    chk("unsigned_valid", out_valid, 1);
    chk("unsigned_max", sum, 42'h3FFFC0001);

    // signed, including both most-negative operands
    drive(1'b1, 17'h1FFFF, 17'h00003, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 17'h10000, 17'h10000, 1'b1, 1'b0, 1'b0);
    tick();
    chk("signed_m1x3", sum, 42'h3FFFFFFFFFD);
    drive(1'b1, 17'h10000, 17'h0FFFF, 1'b1, 1'b0, 1'b0);
    tick();
    chk("signed_minxmin", sum, 42'h100000000);
    in_valid = 1'b0;
    tick();
    chk("signed_minxpos", sum, 42'h3FF00010000);
    tick();
    chk("signed_drain", out_valid, 0);

    // back-to-back dependent accumulation
    drive(1'b1, 17'd3, 17'd4, 1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b1, 17'd5, 17'd6, 1'b0, 1'b1, 1'b0);
    tick();
    chk("acc_clr_12", sum, 42'd12);
    drive(1'b1, 17'd7, 17'd8, 1'b0, 1'b1, 1'b0);
    tick();
    chk("acc_42", sum, 42'd42);
    drive(1'b1, 17'd2, 17'd2, 1'b0, 1'b0, 1'b1);
    tick();
    chk("acc_98", sum, 42'd98);
    drive(1'b1, 17'd1, 17'd1, 1'b0, 1'b1, 1'b0);
    tick();
    chk("noacc_clr_ignored", sum, 42'd4);
    drive(1'b1, 17'h1FFFF, 17'd3, 1'b1, 1'b1, 1'b0);
    tick();
    chk("acc_kept_99", sum, 42'd99);
    in_valid = 1'b0;
    tick();
    chk("acc_signed_96", sum, 42'd96);
    tick();
    chk("acc_drain", out_valid, 0);

    // back-pressure
    out_ready = 1'b0;
    drive(1'b1, 17'd2, 17'd3, 1'b0, 1'b0, 1'b0);
    tick();
    chk("bp_fill", out_valid, 0);
    drive(1'b1, 17'd4, 17'd5, 1'b0, 1'b0, 1'b0);
    tick();
    chk("bp_valid", out_valid, 1);
    chk("bp_first", sum, 42'd6);
    chk("bp_in_ready_low", in_ready, 0);
    drive(1'b1, 17'd6, 17'd7, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("bp_hold_sum", sum, 42'd6);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_second", sum, 42'd20);
    tick();
    chk("bp_third", sum, 42'd42);
    tick();
    chk("bp_drain", out_valid, 0);

    // reset with two transactions in flight
    drive(1'b1, 17'd9, 17'd9, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 17'd10, 17'd10, 1'b0, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("rf_pre", sum, 42'd81);
    rst = 1'b1;
    #1;
    chk("rf_out_valid", out_valid, 0);
    chk("rf_in_ready", in_ready, 0);
    chk("rf_sum", sum, 42'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rf_release_ready", in_ready, 1);
    tick();
    chk("rf_no_stale1", out_valid, 0);
    tick();
    chk("rf_no_stale2", out_valid, 0);
    drive(1'b1, 17'd2, 17'd3, 1'b0, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("rf_lat", out_valid, 0);
    tick();
    chk("rf_after_valid", out_valid, 1);
    chk("rf_after_acc", sum, 42'd6);

    // wrap with ACC_W = N+M on every tree and pipeline depth
    chk("wrap_in_ready", w_ir, 6'h3F);
    for (int t = 1; t <= 6; t++) begin
      w_valid = (t <= 4);
      w_clr   = (t == 1);
      tick();
      for (int i = 0; i < 6; i++) begin
        int p;
        int k;
        p = i % 3 + 1;
        k = t - p;
        if (k >= 0 && k < 4) begin
          chk($sformatf("wrap_valid_m%0d_p%0d_t%0d", i / 3, p, t), w_ov[i], 1);
          chk($sformatf("wrap_sum_m%0d_p%0d_t%0d", i / 3, p, t),
              34'(w_o1[i] + w_o2[i]), 34'((k + 1) * 64'h3FFFC0001));
        end else begin
          chk($sformatf("wrap_idle_m%0d_p%0d_t%0d", i / 3, p, t), w_ov[i], 0);
        end
      end
    end
    w_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ppm_mac.md
PPM_MAC -- requirements
Module: ppm_mac

Interface
REQ-001 SHALL have parameter N, default 17: width of operand a.
REQ-002 SHALL have parameter M, default 17: width of operand b.
REQ-003 SHALL have parameter MULT, default 0: tree select; 0 = wallace, 1 = dadda.
REQ-004 SHALL have parameter PIPE, default 2, legal range 1..3: register stages from acceptance to output, output register included.
REQ-005 SHALL have parameter ACC_W, default N+M+8, minimum N+M: accumulator and output width.
REQ-006 SHALL have one clock and an asynchronous, active-high reset; these are the first two ports.
REQ-007 clk  input  1  sole clock; all state changes on the rising edge.
REQ-008 rst  input  1  asynchronous active-high reset.
REQ-009 in_valid  input  1  operand transaction offered.
REQ-010 in_ready  output  1  block accepts a transaction this cycle.
REQ-011 a  input  N  multiplicand.
REQ-012 b  input  M  multiplier.
REQ-013 tc  input  1  1 = both operands two's complement; 0 = both unsigned.
REQ-014 acc_en  input  1  1 = add the product to the accumulator.
REQ-015 acc_clr  input  1  with acc_en=1, start a new accumulation.
REQ-016 out_valid  output  1  out1/out2 hold a valid result.
REQ-017 out_ready  input  1  consumer takes the result this cycle.
REQ-018 out1, out2  output  ACC_W each  carry-save result; result = (out1+out2) mod 2^ACC_W.

Function
REQ-019 Handshake: transfer occurs when valid and ready are both high on a clock edge; a, b, tc, acc_en and acc_clr are sampled only at in-transfer.
REQ-020 Global enable en = !out_valid || out_ready; every pipeline stage advances only when en=1; in_ready = en.
REQ-021 Latency SHALL be exactly PIPE cycles from in-transfer to out_valid when out_ready stays high; throughput SHALL be one transaction per cycle.
REQ-022 Order SHALL be preserved; no transaction is lost or duplicated under any out_ready pattern.
REQ-023 Product P: sign-extended to ACC_W when tc=1, zero-extended when tc=0; P SHALL be exact for every operand pair, including a = -2^(N-1), b = -2^(M-1).
REQ-024 Product SHALL stay in carry-save form; no carry-propagate adder in the datapath.
REQ-025 acc_en=0: result = P; accumulator unchanged.
REQ-026 acc_en=1, acc_clr=0: result = P + ACC; ACC <= result.
REQ-027 acc_en=1, acc_clr=1: result = P; ACC <= P.
REQ-028 acc_en=0, acc_clr=1: acc_clr ignored.
REQ-029 ACC SHALL be held as a carry-save pair and updated only when the output register loads (en=1 with a valid final stage); back-to-back dependent accumulations SHALL need no stall.
REQ-030 All sums SHALL wrap modulo 2^ACC_W; carry-out is discarded without a flag.
REQ-031 out1/out2 SHALL hold steady while out_valid=1 and out_ready=0.

Reset
REQ-032 While rst=1: in_ready=0, out_valid=0, all stage valids 0, out1=out2=0, ACC pair=0.
REQ-033 Reset mid-operation SHALL discard every in-flight transaction; none emerges after release.
REQ-034 First cycle after release: in_ready=1.

Structure
REQ-035 Shared package ppm_pkg SHALL hold MULT encodings (MULT_WALLACE=0, MULT_DADDA=1) and the ACC_W default function.
REQ-036 Sign handling SHALL use constant correction bits from the package, added in carry-save form.
REQ-037 Natural sub-module: ppm_csa42, a 4:2 carry-save adder built from two compressor32 cells, used for product+ACC and for sign correction.
REQ-038 Tree SHALL be the existing wallace/dadda cell selected by MULT via generate.

Verification
REQ-039 Unsigned: N=M=17, ACC_W=42, a=0x1FFFF, b=0x1FFFF, tc=0, acc_en=0 -> after PIPE cycles, out1+out2 mod 2^42 = 0x3FFFC0001.
REQ-040 Signed: a=0x1FFFF (-1), b=0x00003, tc=1 -> sum = 0x3FFFFFFFFFD (-3).
REQ-041 Accumulate, back-to-back: (3,4,clr), (5,6,acc), (7,8,acc) -> results 12, 42, 98 in consecutive cycles.
REQ-042 Back-pressure: 3 back-to-back inputs, out_ready=0 for 5 cycles -> in_ready low once output holds, out1/out2 frozen, results released in order with no loss.
REQ-043 Reset mid-flight: rst pulse with 2 transactions in flight -> out_valid=0 immediately, no stale output; next (2,3,acc_en=1,clr=0) -> 6.
REQ-044 Wrap: ACC_W=N+M, repeated acc of (0x1FFFF,0x1FFFF) unsigned -> result = k*0x3FFFC0001 mod 2^34, checked on both MULT values and every PIPE value.
